// File: rtl/peripheral_ahb_master_port.sv
// AHB-Lite master port: turns a req/ack command stream into pipelined
// AHB-Lite SINGLE transfers and returns one in-order response pulse per
// command. The next command's address phase overlaps the current data phase.
module peripheral_ahb_master_port #(
  parameter int         HADDR_SIZE    = 32,
  parameter int         HDATA_SIZE    = 32,
  parameter logic [3:0] HPROT_DEFAULT = 4'b0011
) (
  input  logic                  HRESETn,
  input  logic                  HCLK,

  input  logic                  cmd_req,
  output logic                  cmd_ack,
  input  logic [HADDR_SIZE-1:0] cmd_addr,
  input  logic                  cmd_we,
  input  logic [2:0]            cmd_size,
  input  logic [HDATA_SIZE-1:0] cmd_wdata,

  output logic                  rsp_valid,
  output logic [HDATA_SIZE-1:0] rsp_rdata,
  output logic                  rsp_err,

  output logic                  HSEL,
  output logic [HADDR_SIZE-1:0] HADDR,
  output logic [HDATA_SIZE-1:0] HWDATA,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [1:0]            HTRANS,
  output logic                  HMASTLOCK,
  input  logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  localparam logic [2:0] MAX_SIZE      = (HDATA_SIZE == 64) ? 3'd3 : 3'd2;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // A transfer is illegal if it is wider than the bus or not naturally aligned.
  function automatic logic is_misaligned(input logic [2:0] a, input logic [2:0] s);
    logic [2:0] mask;
    case (s)
      3'd0:    mask = 3'b000;
      3'd1:    mask = 3'b001;
      3'd2:    mask = 3'b011;
      default: mask = 3'b111;
    endcase
    return (s > MAX_SIZE) || ((a & mask) != 3'b000);
  endfunction

  logic                  ap_valid;
  logic                  dp_valid;
  logic                  err_hold;
  logic                  dp_we_p1;
  logic [HDATA_SIZE-1:0] ap_wdata_p0;

  logic misaligned;
  logic misalign_block;
  logic issue;
  logic fwd;
  logic done;

  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_DEFAULT;
  assign HMASTLOCK = 1'b0;

  assign misaligned     = is_misaligned(cmd_addr[2:0], cmd_size);
  assign misalign_block = misaligned & (ap_valid | dp_valid);
  assign cmd_ack        = HRESETn & cmd_req & (!ap_valid | HREADY) & !err_hold & !misalign_block;
  assign issue          = cmd_ack & !misaligned;
  assign fwd            = ap_valid & HREADY & (HTRANS == HTRANS_NONSEQ);
  assign done           = dp_valid & HREADY;

  // ---- stage p0: address phase ----
  // Address-phase register; an ERROR on the current data phase parks the
  // pending command (HTRANS=IDLE) and reissues it once the ERROR completes.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ap_valid    <= 1'b0;
      err_hold    <= 1'b0;
      HTRANS      <= HTRANS_IDLE;
      HSEL        <= 1'b0;
      HADDR       <= '0;
      HWRITE      <= 1'b0;
      HSIZE       <= 3'd0;
      ap_wdata_p0 <= '0;
    end else if (issue) begin
      ap_valid    <= 1'b1;
      HTRANS      <= HTRANS_NONSEQ;
      HSEL        <= 1'b1;
      HADDR       <= cmd_addr;
      HWRITE      <= cmd_we;
      HSIZE       <= cmd_size;
      ap_wdata_p0 <= cmd_wdata;
    end else if (err_hold) begin
      if (HREADY) begin
        HTRANS   <= HTRANS_NONSEQ;
        HSEL     <= 1'b1;
        err_hold <= 1'b0;
      end
    end else if (dp_valid && !HREADY && HRESP && ap_valid && (HTRANS == HTRANS_NONSEQ)) begin
      HTRANS   <= HTRANS_IDLE;
      HSEL     <= 1'b0;
      err_hold <= 1'b1;
    end else if (HREADY) begin
      ap_valid <= 1'b0;
      HTRANS   <= HTRANS_IDLE;
      HSEL     <= 1'b0;
    end
  end

  // ---- stage p1: data phase ----
  // Data-phase register; write data is presented one cycle after its address.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_we_p1 <= 1'b0;
      HWDATA   <= '0;
    end else if (fwd) begin
      dp_valid <= 1'b1;
      dp_we_p1 <= HWRITE;
      if (HWRITE) HWDATA <= ap_wdata_p0;
    end else if (done) begin
      dp_valid <= 1'b0;
    end
  end

  // ---- stage p2: response ----
  // One-cycle response pulse for a completed transfer or a rejected command.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else if (done) begin
      rsp_valid <= 1'b1;
      rsp_err   <= HRESP;
      rsp_rdata <= dp_we_p1 ? '0 : HRDATA;
    end else if (cmd_ack && misaligned) begin
      rsp_valid <= 1'b1;
      rsp_err   <= 1'b1;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end
  end

endmodule

// File: tb/tb_peripheral_ahb_master_port.sv
// Directed bench for peripheral_ahb_master_port with a small zero-wait memory
// slave whose HREADY/HRESP are steered cycle by cycle from the stimulus.
module tb_peripheral_ahb_master_port;

  logic        HRESETn;
  logic        HCLK;
  logic        cmd_req;
  logic        cmd_ack;
  logic [31:0] cmd_addr;
  logic        cmd_we;
  logic [2:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HMASTLOCK;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  int n_vec = 0;
  int n_err = 0;

  peripheral_ahb_master_port dut (
    .HRESETn(HRESETn), .HCLK(HCLK),
    .cmd_req(cmd_req), .cmd_ack(cmd_ack), .cmd_addr(cmd_addr), .cmd_we(cmd_we),
    .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Memory slave: 16 words, data phase follows an accepted NONSEQ.
  logic [31:0] mem [16];
  logic        s_active;
  logic        s_write;
  logic [31:0] s_addr;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      s_active <= 1'b0;
      s_write  <= 1'b0;
      s_addr   <= '0;
    end else if (HREADY) begin
      if (s_active && s_write) mem[s_addr[5:2]] <= HWDATA;
      s_active <= HSEL && (HTRANS == 2'b10);
      s_write  <= HWRITE;
      s_addr   <= HADDR;
    end
  end

  assign HRDATA = (s_active && !s_write) ? mem[s_addr[5:2]] : 32'h0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic set_cmd(input logic req, input logic [31:0] a, input logic we,
                         input logic [2:0] sz, input logic [31:0] wd);
    cmd_req   = req;
    cmd_addr  = a;
    cmd_we    = we;
    cmd_size  = sz;
    cmd_wdata = wd;
  endtask

  initial begin
    HRESETn = 1'b0;
    HREADY  = 1'b1;
    HRESP   = 1'b0;
    set_cmd(1'b1, 32'h0, 1'b1, 3'd2, 32'h1);
    tick();
    tick();
    #1;
    chk("rst_htrans", HTRANS, 2'b00);
    chk("rst_hsel", HSEL, 1'b0);
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_ack", cmd_ack, 1'b0);
    chk("const_hburst", HBURST, 3'b000);
    chk("const_hprot", HPROT, 4'b0011);
    chk("const_lock", HMASTLOCK, 1'b0);
    set_cmd(1'b0, 32'h0, 1'b0, 3'd2, 32'h0);
    tick();
    HRESETn = 1'b1;
    tick();

    // Single write 0x3 -> 0x0
    set_cmd(1'b1, 32'h0, 1'b1, 3'd2, 32'h3);
    #1 chk("w1_ack", cmd_ack, 1'b1);
    tick();
    set_cmd(1'b0, 32'h0, 1'b0, 3'd2, 32'h0);
    chk("w1_ap_htrans", HTRANS, 2'b10);
    chk("w1_ap_hsel", HSEL, 1'b1);
    chk("w1_ap_haddr", HADDR, 32'h0);
    chk("w1_ap_hwrite", HWRITE, 1'b1);
    chk("w1_ap_hsize", HSIZE, 3'd2);
    tick();
    chk("w1_dp_htrans", HTRANS, 2'b00);
    chk("w1_dp_hwdata", HWDATA, 32'h3);
    chk("w1_dp_rsp", rsp_valid, 1'b0);
    tick();
    chk("w1_rsp_valid", rsp_valid, 1'b1);
    chk("w1_rsp_err", rsp_err, 1'b0);
    tick();
    chk("w1_rsp_clr", rsp_valid, 1'b0);

    // Back-to-back write 0x55 -> 0x10 then read 0x10
    set_cmd(1'b1, 32'h10, 1'b1, 3'd2, 32'h55);
    #1 chk("b2b_ack0", cmd_ack, 1'b1);
    tick();
    chk("b2b_ap0_htrans", HTRANS, 2'b10);
    set_cmd(1'b1, 32'h10, 1'b0, 3'd2, 32'h0);
    #1 chk("b2b_ack1", cmd_ack, 1'b1);
    tick();
    set_cmd(1'b0, 32'h0, 1'b0, 3'd2, 32'h0);
    chk("b2b_ap1_htrans", HTRANS, 2'b10);
    chk("b2b_ap1_hwrite", HWRITE, 1'b0);
    chk("b2b_dp0_hwdata", HWDATA, 32'h55);
    chk("b2b_early_rsp", rsp_valid, 1'b0);
    tick();
    chk("b2b_rsp0_valid", rsp_valid, 1'b1);
    chk("b2b_rsp0_rdata", rsp_rdata, 32'h0);
    tick();
    chk("b2b_rsp1_valid", rsp_valid, 1'b1);
    chk("b2b_rsp1_rdata", rsp_rdata, 32'h55);
    chk("b2b_rsp1_err", rsp_err, 1'b0);
    tick();
    chk("b2b_rsp_clr", rsp_valid, 1'b0);

    // Wait states: write 0xAA -> 0x20, read 0x0 pending, third command waits
    set_cmd(1'b1, 32'h20, 1'b1, 3'd2, 32'hAA);
    tick();
    set_cmd(1'b1, 32'h0, 1'b0, 3'd2, 32'h0);
    #1 chk("ws_ack1", cmd_ack, 1'b1);
    tick();
    set_cmd(1'b1, 32'h24, 1'b1, 3'd2, 32'h77);
    HREADY = 1'b0;
    #1 chk("ws_ack_blk0", cmd_ack, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("ws_haddr", HADDR, 32'h0);
      chk("ws_hwrite", HWRITE, 1'b0);
      chk("ws_hsize", HSIZE, 3'd2);
      chk("ws_htrans", HTRANS, 2'b10);
      chk("ws_hwdata", HWDATA, 32'hAA);
      chk("ws_rsp", rsp_valid, 1'b0);
      chk("ws_ack_blk", cmd_ack, 1'b0);
    end
    tick();
    chk("ws_haddr_last", HADDR, 32'h0);
    chk("ws_rsp_last", rsp_valid, 1'b0);
    HREADY = 1'b1;
    #1 chk("ws_ack_rel", cmd_ack, 1'b1);
    tick();
    set_cmd(1'b0, 32'h0, 1'b0, 3'd2, 32'h0);
    chk("ws_rsp0_valid", rsp_valid, 1'b1);
    chk("ws_ap2_haddr", HADDR, 32'h24);
    tick();
    chk("ws_rsp1_valid", rsp_valid, 1'b1);
    chk("ws_rsp1_rdata", rsp_rdata, 32'h3);
    chk("ws_dp2_hwdata", HWDATA, 32'h77);
    tick();
    chk("ws_rsp2_valid", rsp_valid, 1'b1);
    chk("ws_rsp2_rdata", rsp_rdata, 32'h0);
    tick();
    chk("ws_rsp_clr", rsp_valid, 1'b0);

    // ERROR on write 0x28 while read 0x10 is pending
    set_cmd(1'b1, 32'h28, 1'b1, 3'd2, 32'h11);
    tick();
    set_cmd(1'b1, 32'h10, 1'b0, 3'd2, 32'h0);
    tick();
    set_cmd(1'b0, 32'h0, 1'b0, 3'd2, 32'h0);
    chk("er_ap_htrans", HTRANS, 2'b10);
    HREADY = 1'b0;
    HRESP  = 1'b1;
    tick();
    chk("er_idle_htrans", HTRANS, 2'b00);
    chk("er_idle_hsel", HSEL, 1'b0);
    chk("er_idle_rsp", rsp_valid, 1'b0);
    HREADY = 1'b1;
    set_cmd(1'b1, 32'h4, 1'b0, 3'd2, 32'h0);
    #1 chk("er_hold_ack", cmd_ack, 1'b0);
    tick();
    set_cmd(1'b0, 32'h0, 1'b0, 3'd2, 32'h0);
    HRESP = 1'b0;
    chk("er_rsp_valid", rsp_valid, 1'b1);
    chk("er_rsp_err", rsp_err, 1'b1);
    chk("er_reissue_htrans", HTRANS, 2'b10);
    chk("er_reissue_haddr", HADDR, 32'h10);
    chk("er_reissue_hwrite", HWRITE, 1'b0);
    tick();
    chk("er_gap_rsp", rsp_valid, 1'b0);
    tick();
    chk("er_rd_valid", rsp_valid, 1'b1);
    chk("er_rd_err", rsp_err, 1'b0);
    chk("er_rd_rdata", rsp_rdata, 32'h55);
    tick();

    // Misaligned word at 0x2 behind an outstanding write
    set_cmd(1'b1, 32'h2C, 1'b1, 3'd2, 32'h9);
    tick();
    set_cmd(1'b1, 32'h2, 1'b0, 3'd2, 32'h0);
    #1 chk("ma_blk_ap", cmd_ack, 1'b0);
    tick();
    chk("ma_no_nonseq", HTRANS, 2'b00);
    chk("ma_blk_dp", cmd_ack, 1'b0);
    tick();
    chk("ma_prev_rsp", rsp_valid, 1'b1);
    chk("ma_prev_err", rsp_err, 1'b0);
    chk("ma_ack", cmd_ack, 1'b1);
    tick();
    set_cmd(1'b0, 32'h0, 1'b0, 3'd2, 32'h0);
    chk("ma_rsp_valid", rsp_valid, 1'b1);
    chk("ma_rsp_err", rsp_err, 1'b1);
    chk("ma_htrans", HTRANS, 2'b00);
    tick();
    chk("ma_rsp_clr", rsp_valid, 1'b0);

    // Oversized (doubleword on 32-bit bus) with empty pipeline
    set_cmd(1'b1, 32'h0, 1'b0, 3'd3, 32'h0);
    #1 chk("os_ack", cmd_ack, 1'b1);
    tick();
    set_cmd(1'b0, 32'h0, 1'b0, 3'd2, 32'h0);
    chk("os_rsp_err", rsp_err, 1'b1);
    chk("os_htrans", HTRANS, 2'b00);
    tick();

    // Reset during a data phase, then a fresh write 0x1 -> 0xC
    set_cmd(1'b1, 32'h30, 1'b1, 3'd2, 32'h5);
    tick();
    set_cmd(1'b0, 32'h0, 1'b0, 3'd2, 32'h0);
    tick();
    HRESETn = 1'b0;
    #1;
    chk("mr_htrans", HTRANS, 2'b00);
    chk("mr_hsel", HSEL, 1'b0);
    chk("mr_rsp", rsp_valid, 1'b0);
    tick();
    HRESETn = 1'b1;
    tick();
    chk("mr_no_rsp", rsp_valid, 1'b0);
    set_cmd(1'b1, 32'hC, 1'b1, 3'd2, 32'h1);
    #1 chk("mr_ack", cmd_ack, 1'b1);
    tick();
    set_cmd(1'b0, 32'h0, 1'b0, 3'd2, 32'h0);
    chk("mr_ap_haddr", HADDR, 32'hC);
    tick();
    chk("mr_hwdata", HWDATA, 32'h1);
    tick();
    chk("mr_rsp_valid", rsp_valid, 1'b1);
    chk("mr_rsp_err", rsp_err, 1'b0);
    set_cmd(1'b1, 32'hC, 1'b0, 3'd2, 32'h0);
    tick();
    set_cmd(1'b0, 32'h0, 1'b0, 3'd2, 32'h0);
    tick();
    tick();
    chk("mr_rd_valid", rsp_valid, 1'b1);
    chk("mr_rd_rdata", rsp_rdata, 32'h1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
